// File: rtl/req_pending_capture.sv
// req_pending_capture
// Synchronises 16 asynchronous request lines, latches their rising edges into
// sticky pending bits and drains them highest-index first through a
// registered valid/ready output stage. Codes are {4'b0000, idx} or 8'hF0.

module req_pending_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] req_in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_code,
    output logic [15:0] pending,
    output logic [7:0]  overflow_cnt
);

    localparam logic [7:0] CODE_NONE = 8'hF0;

    // Synchroniser chain; element SYNC_STAGES-1 is the resynchronised level.
    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] req_s;
    logic [15:0] req_d;
    logic [15:0] rise;

    // Output-stage decode.
    logic        stage_free;
    logic        pend_any;
    logic [3:0]  top_idx;
    logic [15:0] clr;

    // Next-state values.
    logic [15:0] pending_d;
    logic        ovf_hit;
    logic [7:0]  overflow_d;
    logic        out_valid_d;
    logic [7:0]  out_code_d;

    assign req_s = sync_q[SYNC_STAGES-1];

    // Shift req_in through the synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // History flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d <= '0;
        end else begin
            req_d <= req_s;
        end
    end

    // Rising edges are discarded outright while capture is disabled.
    assign rise = req_s & ~req_d & {16{ena}};

    assign stage_free = !out_valid || out_ready;
    assign pend_any   = |pending;

    // Highest set pending index; later iterations win, so bit 15 dominates.
    always_comb begin
        top_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pending[i]) begin
                top_idx = i[3:0];
            end
        end
    end

    // One-hot clear of the bit being loaded into the output stage this edge.
    always_comb begin
        clr = '0;
        if (stage_free && pend_any) begin
            clr[top_idx] = 1'b1;
        end
    end

    // Pending update: a new set on the bit being cleared wins over the clear.
    always_comb begin
        pending_d = (pending & ~clr) | rise;
    end

    // Overflow: any re-hit on a pending bit that is not leaving adds one in total.
    always_comb begin
        ovf_hit    = |(rise & pending & ~clr);
        overflow_d = overflow_cnt;
        if (ovf_hit && (overflow_cnt != 8'hFF)) begin
            overflow_d = overflow_cnt + 8'd1;
        end
    end

    // Output stage: hold on stall, otherwise load the top index or go empty.
    always_comb begin
        out_valid_d = out_valid;
        out_code_d  = out_code;
        if (stage_free) begin
            if (pend_any) begin
                out_valid_d = 1'b1;
                out_code_d  = {4'b0000, top_idx};
            end else begin
                out_valid_d = 1'b0;
                out_code_d  = CODE_NONE;
            end
        end
    end

    // State registers for pending, overflow counter and output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            overflow_cnt <= '0;
            out_valid    <= 1'b0;
            out_code     <= CODE_NONE;
        end else begin
            pending      <= pending_d;
            overflow_cnt <= overflow_d;
            out_valid    <= out_valid_d;
            out_code     <= out_code_d;
        end
    end

endmodule
